sq_tri_scheduler: RTL and testbench



---
 rtl/sq_sched_pkg.sv | 37 +++
 rtl/sq_col_walker.sv | 73 +++++++
 rtl/sq_tri_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_sq_tri_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sq_sched_pkg.sv
// sq_sched_pkg: shared types and helpers for the triangular squaring scheduler.
//   DEF_NUM_ELEMENTS / DEF_LANES : default limb count and multiplier lanes
//   idx_width() / col_width()    : limb-index and column-index widths for a limb count
//   idx_t, lane_beat_t           : index type and one beat of lane data (default sizing)
//   state_t                      : scheduler FSM states
package sq_sched_pkg;

    localparam int DEF_NUM_ELEMENTS = 62;
    localparam int DEF_LANES        = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int col_width(input int n);
        return (n > 1) ? $clog2(2 * n - 1) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_NUM_ELEMENTS);
    localparam int DEF_COL_W = col_width(DEF_NUM_ELEMENTS);

    typedef logic [DEF_IDX_W-1:0] idx_t;

    typedef struct packed {
        idx_t [DEF_LANES-1:0] i;
        idx_t [DEF_LANES-1:0] j;
        logic [DEF_LANES-1:0] vld;
        logic [DEF_LANES-1:0] dbl;
    } lane_beat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sq_col_walker.sv
// sq_col_walker: combinational next-beat generator for the triangular schedule.
// From the current cursor (column k, first limb index of this beat) it produces
// the lane pairs of the beat, the column/schedule end flags and the cursor for
// the following beat. Purely incremental: shift for floor(k/2), adds and compares.
// Ports:
//   col        in   current column k
//   base       in   limb index i carried by lane 0 of this beat
//   lane_i/j   out  per-lane pair indices (0 on unused lanes)
//   lane_vld   out  lane carries a real pair
//   lane_dbl   out  off-diagonal pair (i != j)
//   col_last   out  this beat closes column k
//   sched_last out  this beat closes the final column
//   nxt_col    out  column of the following beat
//   nxt_base   out  lane-0 limb index of the following beat
module sq_col_walker
    import sq_sched_pkg::*;
#(
    parameter  int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
    parameter  int LANES        = DEF_LANES,
    localparam int IDX_W        = idx_width(NUM_ELEMENTS),
    localparam int COL_W        = col_width(NUM_ELEMENTS)
) (
    input  logic [COL_W-1:0]            col,
    input  logic [IDX_W-1:0]            base,
    output logic [LANES-1:0][IDX_W-1:0] lane_i,
    output logic [LANES-1:0][IDX_W-1:0] lane_j,
    output logic [LANES-1:0]            lane_vld,
    output logic [LANES-1:0]            lane_dbl,
    output logic                        col_last,
    output logic                        sched_last,
    output logic [COL_W-1:0]            nxt_col,
    output logic [IDX_W-1:0]            nxt_base
);

    // Wide enough for base+LANES and k-i without wrapping into a false match.
    localparam int SW = COL_W + $clog2(LANES + 1) + 1;
    localparam logic [SW-1:0]    TOP_IDX  = SW'(NUM_ELEMENTS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(2 * NUM_ELEMENTS - 2);

    logic [SW-1:0] k;
    logic [SW-1:0] i_hi;
    logic [SW-1:0] beat_end;
    logic [SW-1:0] k_nxt;
    logic [SW-1:0] lo_nxt;
    logic [SW-1:0] cand [LANES];
    logic [SW-1:0] jv   [LANES];

    always_comb begin
        k        = SW'(col);
        i_hi     = k >> 1;
        beat_end = SW'(base) + SW'(LANES);

        for (int l = 0; l < LANES; l++) begin
            cand[l]     = SW'(base) + SW'(l);
            jv[l]       = k - cand[l];
            lane_vld[l] = (cand[l] <= i_hi);
            lane_i[l]   = lane_vld[l] ? IDX_W'(cand[l]) : '0;
            lane_j[l]   = lane_vld[l] ? IDX_W'(jv[l]) : '0;
            lane_dbl[l] = lane_vld[l] && (cand[l] != jv[l]);
        end

        col_last   = (beat_end > i_hi);
        sched_last = col_last && (col == LAST_COL);

        // First limb of column k+1 is max(0, k+1-(N-1)).
        k_nxt  = k + SW'(1);
        lo_nxt = (k_nxt > TOP_IDX) ? (k_nxt - TOP_IDX) : '0;

        nxt_col  = col_last ? (col + COL_W'(1)) : col;
        nxt_base = col_last ? IDX_W'(lo_nxt) : IDX_W'(beat_end);
    end

endmodule

// File: rtl/sq_tri_scheduler.sv
// sq_tri_scheduler: issues the upper-triangular partial products a[i]*a[j], i<=j,
// of an N-limb squaring onto LANES shared multipliers, column by column (k=i+j).
// Beats never span columns; off-diagonal lanes are flagged for doubling.
// Optional build macro: SQ_SCHED_PERF_EN adds perf_beats / perf_stalls counters.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               begin a schedule (accepted in IDLE only)
//   busy                schedule in progress
//   done                one-cycle pulse after the final beat transfers
//   out_valid/out_ready beat handshake
//   out_i/out_j         per-lane pair indices
//   out_lane_vld        lane carries a real pair
//   out_dbl             lane product counts twice
//   out_col             column k of the beat
//   out_col_last        final beat of column k
//   out_last            final beat of the schedule
//   perf_beats          (SQ_SCHED_PERF_EN) transfers since start, saturating
//   perf_stalls         (SQ_SCHED_PERF_EN) stalled cycles since start, saturating
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; all outputs zero
// RUN   | first cycle primes beat 0, then beats issue on each transfer
// DONE  | done pulse for one cycle, outputs zero, back to IDLE
module sq_tri_scheduler
    import sq_sched_pkg::*;
#(
    parameter  int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
    parameter  int LANES        = DEF_LANES,
    localparam int IDX_W        = idx_width(NUM_ELEMENTS),
    localparam int COL_W        = col_width(NUM_ELEMENTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0][IDX_W-1:0] out_i,
    output logic [LANES-1:0][IDX_W-1:0] out_j,
    output logic [LANES-1:0]            out_lane_vld,
    output logic [LANES-1:0]            out_dbl,
    output logic [COL_W-1:0]            out_col,
    output logic                        out_col_last,
    output logic                        out_last
`ifdef SQ_SCHED_PERF_EN
    ,
    output logic [15:0]                 perf_beats,
    output logic [15:0]                 perf_stalls
`endif
);

    state_t state, state_nxt;

    // Cursor: column and lane-0 limb index of the next beat to load.
    logic [COL_W-1:0] cur_col, cur_col_nxt;
    logic [IDX_W-1:0] cur_base, cur_base_nxt;

    logic                        busy_nxt, done_nxt, valid_nxt;
    logic [LANES-1:0][IDX_W-1:0] i_nxt, j_nxt;
    logic [LANES-1:0]            vld_nxt, dbl_nxt;
    logic [COL_W-1:0]            col_nxt;
    logic                        col_last_nxt, last_nxt;

    logic [LANES-1:0][IDX_W-1:0] w_i, w_j;
    logic [LANES-1:0]            w_vld, w_dbl;
    logic                        w_col_last, w_last;
    logic [COL_W-1:0]            w_nxt_col;
    logic [IDX_W-1:0]            w_nxt_base;

    sq_col_walker #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .LANES        (LANES)
    ) u_walker (
        .col        (cur_col),
        .base       (cur_base),
        .lane_i     (w_i),
        .lane_j     (w_j),
        .lane_vld   (w_vld),
        .lane_dbl   (w_dbl),
        .col_last   (w_col_last),
        .sched_last (w_last),
        .nxt_col    (w_nxt_col),
        .nxt_base   (w_nxt_base)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cur_col      <= '0;
            cur_base     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_valid    <= 1'b0;
            out_i        <= '0;
            out_j        <= '0;
            out_lane_vld <= '0;
            out_dbl      <= '0;
            out_col      <= '0;
            out_col_last <= 1'b0;
            out_last     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cur_col      <= cur_col_nxt;
            cur_base     <= cur_base_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            out_valid    <= valid_nxt;
            out_i        <= i_nxt;
            out_j        <= j_nxt;
            out_lane_vld <= vld_nxt;
            out_dbl      <= dbl_nxt;
            out_col      <= col_nxt;
            out_col_last <= col_last_nxt;
            out_last     <= last_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_col_nxt  = cur_col;
        cur_base_nxt = cur_base;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        valid_nxt    = out_valid;
        i_nxt        = out_i;
        j_nxt        = out_j;
        vld_nxt      = out_lane_vld;
        dbl_nxt      = out_dbl;
        col_nxt      = out_col;
        col_last_nxt = out_col_last;
        last_nxt     = out_last;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = RUN;
                    busy_nxt     = 1'b1;
                    cur_col_nxt  = '0;
                    cur_base_nxt = '0;
                end
            end
            RUN: begin
                // Load a new beat when the output register is empty (priming
                // cycle) or its beat is being taken; otherwise hold for the stall.
                if (!out_valid || out_ready) begin
                    if (out_valid && out_last) begin
                        state_nxt    = DONE;
                        busy_nxt     = 1'b0;
                        done_nxt     = 1'b1;
                        valid_nxt    = 1'b0;
                        i_nxt        = '0;
                        j_nxt        = '0;
                        vld_nxt      = '0;
                        dbl_nxt      = '0;
                        col_nxt      = '0;
                        col_last_nxt = 1'b0;
                        last_nxt     = 1'b0;
                    end else begin
                        valid_nxt    = 1'b1;
                        i_nxt        = w_i;
                        j_nxt        = w_j;
                        vld_nxt      = w_vld;
                        dbl_nxt      = w_dbl;
                        col_nxt      = cur_col;
                        col_last_nxt = w_col_last;
                        last_nxt     = w_last;
                        cur_col_nxt  = w_nxt_col;
                        cur_base_nxt = w_nxt_base;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SQ_SCHED_PERF_EN
    logic start_acc;
    logic xfer;
    logic stall;

    assign start_acc = (state == IDLE) && start;
    assign xfer      = out_valid && out_ready;
    assign stall     = out_valid && !out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_beats  <= '0;
            perf_stalls <= '0;
        end else if (start_acc) begin
            perf_beats  <= '0;
            perf_stalls <= '0;
        end else begin
            if (xfer && (perf_beats != 16'hFFFF)) begin
                perf_beats <= perf_beats + 16'd1;
            end
            if (stall && (perf_stalls != 16'hFFFF)) begin
                perf_stalls <= perf_stalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sq_tri_scheduler.sv
// Bench for sq_tri_scheduler: a small (N=4, LANES=2) and a full-size (N=62, LANES=8)
// instance, each compared every cycle against a column-walk reference model.
module tb_sq_tri_scheduler;

    typedef struct packed {
        logic [7:0]      col;
        logic            col_last;
        logic            last;
        logic [7:0][7:0] i;
        logic [7:0][7:0] j;
        logic [7:0]      vld;
        logic [7:0]      dbl;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // small instance
    logic            reset_s, start_s, ready_s;
    logic            s_busy, s_done, s_valid, s_cl, s_last;
    logic [1:0][1:0] s_i, s_j;
    logic [1:0]      s_vld, s_dbl;
    logic [2:0]      s_col;
    // big instance
    logic            reset_b, start_b, ready_b;
    logic            b_busy, b_done, b_valid, b_cl, b_last;
    logic [7:0][5:0] b_i, b_j;
    logic [7:0]      b_vld, b_dbl;
    logic [6:0]      b_col;
`ifdef SQ_SCHED_PERF_EN
    logic [15:0]     s_pb, s_ps, b_pb, b_ps;
`endif

    sq_tri_scheduler #(.NUM_ELEMENTS(4), .LANES(2)) dut_s (
        .clk(clk), .reset(reset_s), .start(start_s), .busy(s_busy), .done(s_done),
        .out_valid(s_valid), .out_ready(ready_s), .out_i(s_i), .out_j(s_j),
        .out_lane_vld(s_vld), .out_dbl(s_dbl), .out_col(s_col),
        .out_col_last(s_cl), .out_last(s_last)
`ifdef SQ_SCHED_PERF_EN
        , .perf_beats(s_pb), .perf_stalls(s_ps)
`endif
    );

    sq_tri_scheduler #(.NUM_ELEMENTS(62), .LANES(8)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .busy(b_busy), .done(b_done),
        .out_valid(b_valid), .out_ready(ready_b), .out_i(b_i), .out_j(b_j),
        .out_lane_vld(b_vld), .out_dbl(b_dbl), .out_col(b_col),
        .out_col_last(b_cl), .out_last(b_last)
`ifdef SQ_SCHED_PERF_EN
        , .perf_beats(b_pb), .perf_stalls(b_ps)
`endif
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // idx-th beat of the schedule, walking columns with plain arithmetic.
    function automatic beat_t model_beat(input int n, input int lanes, input int idx);
        beat_t r;
        int    rem;
        bit    found;
        r     = '0;
        rem   = idx;
        found = 0;
        for (int k = 0; k <= 2 * n - 2; k++) begin
            int lo, hi, c, nb;
            if (!found) begin
                lo = (k > n - 1) ? k - (n - 1) : 0;
                hi = k / 2;
                c  = hi - lo + 1;
                nb = (c + lanes - 1) / lanes;
                if (rem < nb) begin
                    found      = 1;
                    r.col      = 8'(k);
                    r.col_last = (rem == nb - 1);
                    r.last     = (rem == nb - 1) && (k == 2 * n - 2);
                    for (int l = 0; l < lanes; l++) begin
                        int ii;
                        ii = lo + rem * lanes + l;
                        if (ii <= hi) begin
                            r.vld[l] = 1'b1;
                            r.i[l]   = 8'(ii);
                            r.j[l]   = 8'(k - ii);
                            r.dbl[l] = (ii != k - ii);
                        end
                    end
                end else begin
                    rem = rem - nb;
                end
            end
        end
        return r;
    endfunction

    function automatic void model_total(input int n, input int lanes, output int beats, output int nlanes);
        beats  = 0;
        nlanes = 0;
        for (int k = 0; k <= 2 * n - 2; k++) begin
            int lo, hi;
            lo = (k > n - 1) ? k - (n - 1) : 0;
            hi = k / 2;
            beats  += (hi - lo + 1 + lanes - 1) / lanes;
            nlanes += hi - lo + 1;
        end
    endfunction

    // ---------------- compare process ----------------
    int    epoch      [2];
    int    seen_epoch [2];
    int    bcnt       [2];
    int    lane_tot   [2];
    int    cl_tot     [2];
    bit    prev_stall [2];
    beat_t prev_beat  [2];
    bit    exp_done   [2];
    int    c61_beats, c61_last;
    int    pair_cnt [62][62];

    always @(negedge clk) begin
        beat_t a, e;
        logic  v, r, dn, rs, bz;
        int    nn, ll, bad;
        for (int d = 0; d < 2; d++) begin
            a = '0;
            if (d == 0) begin
                for (int l = 0; l < 2; l++) begin
                    a.i[l] = 8'(s_i[l]);
                    a.j[l] = 8'(s_j[l]);
                end
                a.vld = 8'(s_vld); a.dbl = 8'(s_dbl); a.col = 8'(s_col);
                a.col_last = s_cl; a.last = s_last;
                v = s_valid; r = ready_s; dn = s_done; rs = reset_s; bz = s_busy;
                nn = 4; ll = 2;
            end else begin
                for (int l = 0; l < 8; l++) begin
                    a.i[l] = 8'(b_i[l]);
                    a.j[l] = 8'(b_j[l]);
                end
                a.vld = b_vld; a.dbl = b_dbl; a.col = 8'(b_col);
                a.col_last = b_cl; a.last = b_last;
                v = b_valid; r = ready_b; dn = b_done; rs = reset_b; bz = b_busy;
                nn = 62; ll = 8;
            end

            if (rs) begin
                chk("reset_zero", 160'({v, dn, bz, a}), '0);
                bcnt[d] = 0; lane_tot[d] = 0; cl_tot[d] = 0;
                prev_stall[d] = 0; exp_done[d] = 0;
            end else begin
                if (epoch[d] != seen_epoch[d]) begin
                    seen_epoch[d] = epoch[d];
                    bcnt[d] = 0; lane_tot[d] = 0; cl_tot[d] = 0;
                    prev_stall[d] = 0; exp_done[d] = 0;
                    if (d == 1) begin
                        c61_beats = 0; c61_last = 0;
                        for (int x = 0; x < 62; x++)
                            for (int y = 0; y < 62; y++) pair_cnt[x][y] = 0;
                    end
                end

                chk("done_pulse", 160'(dn), 160'(exp_done[d]));
                exp_done[d] = 0;

                if (v) begin
                    if (prev_stall[d]) chk("stall_hold", a, prev_beat[d]);
                    if (r) begin
                        e = model_beat(nn, ll, bcnt[d]);
                        chk("beat", a, e);
                        bcnt[d]++;
                        lane_tot[d] += $countones(a.vld);
                        if (a.col_last) cl_tot[d]++;
                        if (d == 1) begin
                            if (a.col == 8'd61) begin
                                c61_beats++;
                                c61_last = $countones(a.vld);
                            end
                            for (int l = 0; l < 8; l++)
                                if (a.vld[l] && a.i[l] < 62 && a.j[l] < 62)
                                    pair_cnt[a.i[l]][a.j[l]]++;
                        end
                        if (e.last) exp_done[d] = 1;
                        prev_stall[d] = 0;
                    end else begin
                        prev_stall[d] = 1;
                        prev_beat[d]  = a;
                    end
                end else begin
                    if (prev_stall[d]) chk("valid_drop", 160'(v), 160'(1));
                    chk("idle_zero", a, '0);
                    prev_stall[d] = 0;
                end

                if (dn) begin
                    if (d == 0) begin
                        chk("s_beats", 160'(bcnt[0]), 160'(7));
                        chk("s_lanes", 160'(lane_tot[0]), 160'(10));
                        chk("s_col_last", 160'(cl_tot[0]), 160'(7));
                    end else begin
                        bad = 0;
                        for (int x = 0; x < 62; x++)
                            for (int y = x; y < 62; y++)
                                if (pair_cnt[x][y] != 1) bad++;
                        chk("b_beats", 160'(bcnt[1]), 160'(300));
                        chk("b_lanes", 160'(lane_tot[1]), 160'(1953));
                        chk("b_col_last", 160'(cl_tot[1]), 160'(123));
                        chk("b_col61_beats", 160'(c61_beats), 160'(4));
                        chk("b_col61_last_lanes", 160'(c61_last), 160'(7));
                        chk("b_pairs_once", 160'(bad), 160'(0));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int    cyc, nb, nl;
        beat_t e;
        reset_s = 1; reset_b = 1; start_s = 0; start_b = 0; ready_s = 1; ready_b = 1;
        epoch[0] = 0; epoch[1] = 0; seen_epoch[0] = 0; seen_epoch[1] = 0;

        // pin the model against hand-derived values
        e = model_beat(4, 2, 2);
        chk("model_col2", 160'({e.col, e.vld, e.i[0], e.j[0], e.dbl[0], e.i[1], e.j[1], e.dbl[1]}),
            160'({8'd2, 8'b11, 8'd0, 8'd2, 1'b1, 8'd1, 8'd1, 1'b0}));
        e = model_beat(4, 2, 5);
        chk("model_col5", 160'({e.col, e.vld, e.i[0], e.j[0], e.dbl[0]}),
            160'({8'd5, 8'b01, 8'd2, 8'd3, 1'b1}));
        model_total(4, 2, nb, nl);
        chk("model_tot_small", 160'({nb, nl}), 160'({32'd7, 32'd10}));
        model_total(62, 8, nb, nl);
        chk("model_tot_big", 160'({nb, nl}), 160'({32'd300, 32'd1953}));

        tick(2);
        chk("rst_small", 160'({s_valid, s_busy, s_done, s_col, s_cl, s_last, s_vld, s_i, s_j, s_dbl}), '0);
        chk("rst_big", 160'({b_valid, b_busy, b_done, b_col, b_cl, b_last, b_vld, b_dbl}), '0);
        reset_s = 0; reset_b = 0;
        tick(2);

        // N=4 LANES=2, ready always high
        epoch[0]++;
        start_s = 1; tick(1); start_s = 0;
        chk("s_busy_run", 160'(s_busy), 160'(1));
        chk("s_prime_invalid", 160'(s_valid), 160'(0));
        cyc = 1;
        while (!s_done && cyc < 100) begin tick(1); cyc++; end
        chk("s_latency", 160'(cyc), 160'(9));
        chk("s_busy_done", 160'(s_busy), 160'(0));
        tick(3);

        // N=62 LANES=8, ready always high
        epoch[1]++;
        start_b = 1; tick(1); start_b = 0;
        cyc = 1;
        while (!b_done && cyc < 1000) begin tick(1); cyc++; end
        chk("b_latency", 160'(cyc), 160'(302));
        tick(3);

        // random ready at ~30% duty
        epoch[1]++;
        start_b = 1; tick(1); start_b = 0;
        cyc = 1;
        while (!b_done && cyc < 5000) begin
            ready_b = ($urandom_range(0, 99) < 30);
            tick(1);
            cyc++;
        end
        chk("rand_finished", 160'(b_done), 160'(1));
        ready_b = 1;
        tick(4);

        // start during RUN and DONE ignored; held start restarts from IDLE
        epoch[1]++;
        start_b = 1; tick(1); start_b = 0;
        cyc = 1;
        repeat (40) begin tick(1); cyc++; end
        start_b = 1;
        repeat (3) begin tick(1); cyc++; end
        start_b = 0;
        while (cyc < 299) begin tick(1); cyc++; end
        start_b = 1;
        while (!b_done && cyc < 1000) begin tick(1); cyc++; end
        chk("run_start_ignored_latency", 160'(cyc), 160'(302));
        chk("done_busy_low", 160'(b_busy), 160'(0));
        tick(1);
        epoch[1]++;
        chk("idle_after_done", 160'({b_busy, b_valid, b_done}), 160'(0));
        tick(1);
        start_b = 0;
        chk("restart_busy", 160'(b_busy), 160'(1));
        cyc = 1;
        while (!b_done && cyc < 1000) begin tick(1); cyc++; end
        chk("restart_latency", 160'(cyc), 160'(302));
        tick(3);

        // reset mid-schedule at beat 150
        epoch[1]++;
        start_b = 1; tick(1); start_b = 0;
        cyc = 1;
        while (bcnt[1] < 150 && cyc < 1000) begin tick(1); cyc++; end
        e = model_beat(62, 8, 150);
        chk("pre_reset_valid", 160'(b_valid), 160'(1));
        chk("pre_reset_col", 160'(b_col), 160'(e.col));
        reset_b = 1;
        #1;
        chk("reset_abort", 160'({b_valid, b_busy, b_done, b_col, b_cl, b_last, b_vld, b_dbl, b_i, b_j}), '0);
        tick(2);
        reset_b = 0;
        tick(1);
        epoch[1]++;
        start_b = 1; tick(1); start_b = 0;
        tick(1);
        chk("replay_first", 160'({b_valid, b_col, b_vld}), 160'({1'b1, 7'd0, 8'b0000_0001}));
        cyc = 2;
        while (!b_done && cyc < 1000) begin tick(1); cyc++; end
        chk("replay_latency", 160'(cyc), 160'(302));
        tick(3);

`ifdef SQ_SCHED_PERF_EN
        epoch[0]++;
        start_s = 1; tick(1); start_s = 0;
        tick(1);
        ready_s = 0;
        tick(3);
        ready_s = 1;
        cyc = 0;
        while (!s_done && cyc < 100) begin tick(1); cyc++; end
        chk("perf_beats", 160'(s_pb), 160'(7));
        chk("perf_stalls", 160'(s_ps), 160'(3));
        tick(3);
        chk("perf_hold", 160'({s_pb, s_ps}), 160'({16'd7, 16'd3}));
        chk("perf_big_beats", 160'(b_pb), 160'(300));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
